// File: rtl/control_mascara_pkg.sv
// Shared definitions for the mask-coefficient loader: sequencer state encoding
// and the decoded register-bank addresses (only bits [1:0] of the bus select).
// No ports; imported by the loader top.
package control_mascara_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    LEER   = 2'd1,
    DRENAR = 2'd2,
    FIN    = 2'd3
  } estado_t;

  localparam logic [1:0] DIR_TAMANO  = 2'd0;
  localparam logic [1:0] DIR_BASE    = 2'd1;
  localparam logic [1:0] DIR_CONTROL = 2'd2;
  localparam logic [1:0] DIR_ERROR   = 2'd3;

endpackage

// File: rtl/FlipFlopD_Habilitado.sv
// Purpose: BITS-wide D register with load enable and synchronous active-high clear.
// Latency: 1 cycle from d_i/habilitacion_i to q_o. Backpressure: none.
// Ports: clk_i, reset_i, habilitacion_i (load enable), d_i (data in), q_o (stored value).
module FlipFlopD_Habilitado #(
  parameter int BITS = 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            habilitacion_i,
  input  logic [BITS-1:0] d_i,
  output logic [BITS-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_o <= '0;
    end else if (habilitacion_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/control_mascara_carga.sv
// Purpose: register bank + sequencer that streams t*t mask coefficients from memory.
// Latency: load starts 2 cycles after the triggering write; coefficient 1 cycle after its read.
// Backpressure: none; bank writes to 0..2 while busy are dropped and flag error_escritura.
// Ports: direccion/datos/habilitacion_registros = register write bus; mem_* = coefficient
//   memory (1-cycle read latency); coef_* = coefficient stream; tamano_mascara,
//   direccion_mem_inicio_mascara = register contents; ocupado, mascara_lista, error_escritura = status.
module control_mascara_carga
  import control_mascara_pkg::*;
#(
  parameter int BITS_BUS_DATOS     = 21,
  parameter int BITS_BUS_DIRECCION = 11,
  parameter int BITS_DIRECCION_MEM = 10,
  parameter int BITS_MASCARA       = 3,
  parameter int BITS_COEFICIENTE   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BITS_BUS_DIRECCION-1:0] direccion_registros,
  input  logic [BITS_BUS_DATOS-1:0]     datos_registros,
  input  logic                          habilitacion_registros,
  output logic [BITS_DIRECCION_MEM-1:0] mem_direccion,
  output logic                          mem_lectura,
  input  logic [BITS_COEFICIENTE-1:0]   mem_datos,
  output logic [BITS_COEFICIENTE-1:0]   coef_datos,
  output logic [2*BITS_MASCARA-1:0]     coef_indice,
  output logic                          coef_valido,
  output logic [BITS_MASCARA-1:0]       tamano_mascara,
  output logic [BITS_DIRECCION_MEM-1:0] direccion_mem_inicio_mascara,
  output logic                          ocupado,
  output logic                          mascara_lista,
  output logic                          error_escritura
);

  localparam int BI = 2 * BITS_MASCARA;

  estado_t                         estado_q, estado_d;
  logic [BI-1:0]                   contador_q, contador_d;
  logic [BI-1:0]                   total, ultimo;
  logic [BITS_MASCARA-1:0]         tamano_q;
  logic [BITS_DIRECCION_MEM-1:0]   base_q, base_prev_q;
  logic                            recarga_q, error_q, error_d, valido_q;
  logic [BI-1:0]                   indice_q;
  logic [BITS_COEFICIENTE-1:0]     datos_q;
  logic [1:0]                      sel;
  logic                            acepta, hab_tamano, hab_base, pide_recarga, inicio;
  logic                            unused_bits;

  assign unused_bits = ^{direccion_registros[BITS_BUS_DIRECCION-1:2],
                         datos_registros[BITS_BUS_DATOS-1:BITS_DIRECCION_MEM]};

  // ---------------- register bank ----------------
  assign sel          = direccion_registros[1:0];
  assign acepta       = habilitacion_registros && !ocupado;
  assign hab_tamano   = acepta && (sel == DIR_TAMANO);
  assign hab_base     = acepta && (sel == DIR_BASE);
  assign pide_recarga = acepta && (sel == DIR_CONTROL) && datos_registros[0];

  FlipFlopD_Habilitado #(.BITS(BITS_MASCARA)) u_tamano (
    .clk_i(clk), .reset_i(reset), .habilitacion_i(hab_tamano),
    .d_i(datos_registros[BITS_MASCARA-1:0]), .q_o(tamano_q)
  );

  FlipFlopD_Habilitado #(.BITS(BITS_DIRECCION_MEM)) u_base (
    .clk_i(clk), .reset_i(reset), .habilitacion_i(hab_base),
    .d_i(datos_registros[BITS_DIRECCION_MEM-1:0]), .q_o(base_q)
  );

  // Delayed copy of the base: a real change of value shows up as a one-cycle
  // mismatch, while rewriting the same value never does.
  FlipFlopD_Habilitado #(.BITS(BITS_DIRECCION_MEM)) u_base_prev (
    .clk_i(clk), .reset_i(reset), .habilitacion_i(1'b1),
    .d_i(base_q), .q_o(base_prev_q)
  );

  // Address 3 always clears, even while busy; dropped writes set the flag.
  always_comb begin
    error_d = error_q;
    if (habilitacion_registros) begin
      if (sel == DIR_ERROR)  error_d = 1'b0;
      else if (ocupado)      error_d = 1'b1;
    end
  end

  // ---------------- sequencer ----------------
  assign total  = BI'(tamano_q) * BI'(tamano_q);
  assign ultimo = total - BI'(1);
  assign inicio = (base_q != base_prev_q) || recarga_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= REPOSO;
      contador_q <= '0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    case (estado_q)
      REPOSO: begin
        if (inicio) begin
          contador_d = '0;
          estado_d   = (tamano_q == '0) ? FIN : LEER;
        end
      end
      LEER: begin
        contador_d = contador_q + BI'(1);
        if (contador_q == ultimo) estado_d = DRENAR;
      end
      DRENAR:  estado_d = FIN;
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  always_comb begin
    mem_lectura   = (estado_q == LEER);
    ocupado       = (estado_q != REPOSO);
    mascara_lista = (estado_q == FIN);
    mem_direccion = '0;
    // Narrowing the sum to the memory width gives the modulo wrap for free.
    if (estado_q == LEER) mem_direccion = base_q + BITS_DIRECCION_MEM'(contador_q);
  end

  // Read data comes back one cycle after the read; the index is held alongside.
  always_ff @(posedge clk) begin
    if (reset) begin
      recarga_q <= 1'b0;
      error_q   <= 1'b0;
      valido_q  <= 1'b0;
      indice_q  <= '0;
      datos_q   <= '0;
    end else begin
      recarga_q <= pide_recarga;
      error_q   <= error_d;
      valido_q  <= mem_lectura;
      if (mem_lectura) indice_q <= contador_q;
      if (valido_q)    datos_q  <= mem_datos;
    end
  end

  assign coef_valido                  = valido_q;
  assign coef_datos                   = valido_q ? mem_datos : datos_q;
  assign coef_indice                  = indice_q;
  assign tamano_mascara               = tamano_q;
  assign direccion_mem_inicio_mascara = base_q;
  assign error_escritura              = error_q;

endmodule

// File: doc/control_mascara_carga.md
CONTROL_MASCARA_CARGA -- requirements
Module: control_mascara_carga

Interface
REQ-001 SHALL have parameter BITS_BUS_DATOS, default 21, width of the register-write data bus.
REQ-002 SHALL have parameter BITS_BUS_DIRECCION, default 11, width of the register-write address bus.
REQ-003 SHALL have parameter BITS_DIRECCION_MEM, default 10, width of the coefficient memory address.
REQ-004 SHALL have parameter BITS_MASCARA, default 3, width of the mask side length t.
REQ-005 SHALL have parameter BITS_COEFICIENTE, default 8, width of one mask coefficient.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high.
REQ-008 SHALL have port direccion_registros, input, BITS_BUS_DIRECCION, register select; only bits [1:0] are decoded.
REQ-009 SHALL have port datos_registros, input, BITS_BUS_DATOS, register write data.
REQ-010 SHALL have port habilitacion_registros, input, 1, write strobe.
REQ-011 SHALL have port mem_direccion, output, BITS_DIRECCION_MEM, coefficient read address.
REQ-012 SHALL have port mem_lectura, output, 1, read enable.
REQ-013 SHALL have port mem_datos, input, BITS_COEFICIENTE, read data, fixed 1-cycle latency after mem_lectura.
REQ-014 SHALL have port coef_datos, output, BITS_COEFICIENTE, streamed coefficient.
REQ-015 SHALL have port coef_indice, output, 2*BITS_MASCARA, coefficient index 0..t*t-1.
REQ-016 SHALL have port coef_valido, output, 1, coef_datos/coef_indice qualifier.
REQ-017 SHALL have ports tamano_mascara (BITS_MASCARA) and direccion_mem_inicio_mascara (BITS_DIRECCION_MEM), outputs, current register contents.
REQ-018 SHALL have ports ocupado, mascara_lista and error_escritura, outputs, 1 bit each.

Function
REQ-019 SHALL decode writes when habilitacion_registros=1: [1:0]=0 tamano, 1 base address, 2 control (bit0=1 forces reload), 3 clears error_escritura.
REQ-020 SHALL discard writes to addresses 0, 1 and 2 while ocupado=1 and set error_escritura (sticky); writes to address 3 are always accepted.
REQ-021 SHALL start a load when the base register differs from its one-cycle-delayed copy, or one cycle after an accepted control write with bit0=1; rewriting an identical base SHALL NOT start a load.
REQ-022 SHALL implement FSM REPOSO -> LEER -> DRENAR -> FIN -> REPOSO; REPOSO goes directly to FIN when t=0.
REQ-023 Timing: write in cycle 0, register updated cycle 1, FSM in LEER from cycle 2.
REQ-024 In LEER, SHALL assert mem_lectura for exactly t*t consecutive cycles with mem_direccion = base+i, i=0..t*t-1.
REQ-025 mem_direccion SHALL wrap modulo 2^BITS_DIRECCION_MEM.
REQ-026 SHALL assert coef_valido one cycle after each read, with coef_datos=mem_datos and coef_indice=i.
REQ-027 SHALL enter DRENAR for the last coef_valido cycle, then FIN for one cycle with mascara_lista=1 (single-cycle pulse).
REQ-028 ocupado SHALL be 1 in LEER, DRENAR and FIN.
REQ-029 The load count SHALL be computed as t*t in 2*BITS_MASCARA bits without truncation (t=7 gives 49).
REQ-030 Outputs coef_datos and coef_indice SHALL hold their last values when coef_valido=0.

Reset
REQ-031 On reset=1, SHALL return FSM to REPOSO regardless of state, abandoning any load in progress.
REQ-032 On reset=1, SHALL clear all registers, the delayed base copy and error_escritura, and drive every output to 0.
REQ-033 SHALL NOT start a load after reset deasserts, since the base register and its delayed copy are equal.

Structure
REQ-034 SHALL place FSM state encodings and register addresses 0..3 in shared package control_mascara_pkg.
REQ-035 SHALL build the tamano, base and delayed-base registers from the existing sub-module FlipFlopD_Habilitado.
REQ-036 SHALL implement the sequencer (FSM, index counter, address adder) inline.

Verification
REQ-037 Write tamano=3, then base=0x010 -> mem_lectura cycles 2..10 at 0x010..0x018; coef_valido cycles 3..11, indices 0..8; mascara_lista in cycle 12.
REQ-038 Write tamano=2, then base=0x3FE -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-039 Write tamano=0, then control bit0=1 -> no mem_lectura; mascara_lista and ocupado high for exactly one cycle.
REQ-040 During a load, write base=0x020 -> write discarded, error_escritura=1, load completes unchanged; write address 3 -> error_escritura=0.
REQ-041 Assert reset mid-LEER with tamano=5 -> next cycle all outputs 0, FSM in REPOSO, no further reads.
REQ-042 Rewrite the same base value -> no load; then write control bit0=1 -> full t*t reload.
